// File: rtl/carry4_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : carry4_serial_sub
// Brief    : Serial subtractor, D = A - B - BIN, one CARRY4-style slice/cycle.
//            Optional signed overflow flag: define CARRY4_SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module carry4_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             OVF
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] c_K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  nb_q, nb_d;
    logic              carry_q, carry_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              bout_q, bout_d;

    logic [3:0]        w_di;
    logic [3:0]        w_s;
    logic [3:0]        w_o;
    logic              w_c;
    logic              w_last;

    // One CARRY4 stage: propagate on S, otherwise the carry comes from DI.
    always_comb begin
        w_di = a_q[{k_q, 2'b00} +: 4];
        w_s  = w_di ^ nb_q[{k_q, 2'b00} +: 4];
        w_c  = carry_q;
        w_o  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_o[i] = w_s[i] ^ w_c;
            w_c    = w_s[i] ? w_c : w_di[i];
        end
    end

    assign w_last = (state_q == S_RUN) && (k_q == c_K_LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        k_d     = k_q;
        d_d     = d_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    nb_d    = ~B;
                    carry_d = ~BIN;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_d[{k_q, 2'b00} +: 4] = w_o;
                carry_d = w_c;
                k_d     = k_q + KW'(1);
                if (w_last) begin
                    k_d     = '0;
                    bout_d  = ~w_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

`ifdef CARRY4_SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // nb_q holds ~B, so the B sign is the inverse of its MSB; w_o[3] is the new D MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (w_last) begin
            ovf_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (w_o[3] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign D         = d_q;
    assign BOUT      = bout_q;

endmodule
`default_nettype wire

// File: doc/carry4_serial_sub.md
# carry4_serial_sub

- Sequential subtractor: D = A − B − BIN, computed over WIDTH/4 cycles, one 4-bit slice per cycle.
- Each cycle's slice uses the same carry semantics as a CARRY4 stage: CIN = ¬borrow, S = A ^ ¬B, DI = A.
- It is the borrow-direction counterpart of the carry-chain adder, for small-area designs that need subtraction without a full-width chain.
- It sits between a valid/ready producer and consumer.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4; N = WIDTH/4 slices.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- BIN  input  1  borrow in.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- D  output  WIDTH  difference.
- BOUT  output  1  borrow out; 1 when A < B + BIN as unsigned.
- OVF  output  1  signed overflow; see Configuration.

## Operation
- Three-state FSM:
  - **IDLE**: IN_READY=1. On IN_VALID=1, latch A, ¬B and carry = ¬BIN, clear slice counter k, go to RUN.
  - **RUN**: each cycle, compute slice k:
    - s = A[4k+3:4k] ^ ¬B[4k+3:4k]
    - sum = A[4k+3:4k] + ¬B[4k+3:4k] + carry, 5-bit result
    - D[4k+3:4k] ← sum[3:0]
    - carry ← sum[4]
    - k ← k+1
    - When k = N−1 completes, go to DONE.
  - **DONE**: OUT_VALID=1. On OUT_READY=1, go to IDLE.
- BOUT = ¬(final carry), registered on the last RUN edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- IN_READY is 1 only in IDLE. IN_VALID is ignored in RUN and DONE; operands are not re-sampled.
- D, BOUT and OVF hold stable for the whole of DONE. They keep their last values in IDLE until the next result overwrites them slice by slice.
- k wraps to 0 on entry to RUN; it never exceeds N−1.

## Timing
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, D=0, BOUT=0, OVF=0, k=0.
- RST has priority over every handshake. RST in RUN or DONE aborts the operation with no output; the next cycle is IDLE with the reset values.
- Latency: the accept edge is cycle 0. Slice edges are cycles 1..N. OUT_VALID rises after edge N, i.e. N cycles after accept (4 for WIDTH=16).
- Minimum initiation interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with OUT_READY=1. IDLE is then re-entered and a new accept can occur on that IDLE cycle.
- OUT_READY may be high before OUT_VALID. The handshake completes on the first DONE cycle.
- OUT_VALID falls on the edge after OUT_VALID & OUT_READY.

## Configuration
- Macro: CARRY4_SERIAL_SUB_OVF_EN.
- **Defined**:
  - On the last RUN edge, OVF ← (A[WIDTH−1] ≠ B[WIDTH−1]) & (D[WIDTH−1] ≠ A[WIDTH−1]).
  - A and B are the latched operands; D[WIDTH−1] is the new MSB.
  - This adds one register and no extra latency.
- **Undefined**: OVF is tied to 0, no logic is generated, and the port remains present.

## Test plan
- WIDTH=16, A=0x1234, B=0x0234, BIN=0 → OUT_VALID 4 cycles after accept, D=0x1000, BOUT=0.
- A=0x0000, B=0x0001, BIN=0 → D=0xFFFF, BOUT=1; with OVF_EN, OVF=0.
- A=0x0005, B=0x0003, BIN=1 → D=0x0001, BOUT=0; then A=0x0003, B=0x0003, BIN=1 → D=0xFFFF, BOUT=1.
- Backpressure:
  - Stimulus: OUT_READY=0 for 10 cycles after OUT_VALID rises, and IN_VALID=1 held throughout with different operands.
  - Required: OUT_VALID=1 and D held stable, IN_READY=0, new operands not latched.
  - After OUT_READY=1: one cycle later IN_READY=1, and the new operands are accepted.
- RST=1 for one cycle at RUN slice 2 → next cycle IN_READY=1, OUT_VALID=0, D=0, BOUT=0. A following op 0x00FF−0x000F gives D=0x00F0 with the full 4-cycle latency.
- With OVF_EN: A=0x8000, B=0x0001, BIN=0 → D=0x7FFF, OVF=1, BOUT=0. Without OVF_EN, the same stimulus gives OVF=0.
